// File: rtl/jt49_div_sched.sv
// Time-shared tone/noise divider engine: four divider contexts (A, B, C, N) served by one comparator and one incrementer.
// Latency: cen sampled at edge k updates div_a at k+1, div_b at k+2, div_c at k+3 and div_n at k+4.
// Backpressure: none; a cen that arrives in SA/SB/SC is dropped and flagged by the sticky overrun output.
module jt49_div_sched #(
  parameter int W  = 12,
  parameter int NW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [W-1:0]  period_a,
  input  logic [W-1:0]  period_b,
  input  logic [W-1:0]  period_c,
  input  logic [NW-1:0] period_n,
  input  logic [3:0]    chan_rst,
  input  logic          ovr_clr,
  output logic          div_a,
  output logic          div_b,
  output logic          div_c,
  output logic          div_n,
  output logic          busy,
  output logic          overrun
);

  typedef enum logic [2:0] {IDLE, SA, SB, SC, SN} state_t;

  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  state_t       state, state_nxt;
  logic         drop;
  logic         svc;
  logic [1:0]   slot;
  logic [W-1:0] cnt [4];
  logic [3:0]   divq;
  logic [W-1:0] cur_cnt;
  logic [W-1:0] cur_per;
  logic         hit;
  logic [W-1:0] cnt_inc;

  // Scheduler: one round SA..SN per accepted cen; a cen in SN chains straight into the next round.
  always_comb begin
    state_nxt = state;
    drop      = 1'b0;
    case (state)
      IDLE: if (cen) state_nxt = SA;
      SA: begin
        state_nxt = SB;
        drop      = cen;
      end
      SB: begin
        state_nxt = SC;
        drop      = cen;
      end
      SC: begin
        state_nxt = SN;
        drop      = cen;
      end
      SN:      state_nxt = cen ? SA : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slot decode and shared operand mux: the only comparator and incrementer in the block sit behind it.
  always_comb begin
    svc     = 1'b1;
    slot    = 2'd0;
    cur_per = period_a;
    case (state)
      SA: begin
        slot    = 2'd0;
        cur_per = period_a;
      end
      SB: begin
        slot    = 2'd1;
        cur_per = period_b;
      end
      SC: begin
        slot    = 2'd2;
        cur_per = period_c;
      end
      SN: begin
        slot    = 2'd3;
        cur_per = {{(W-NW){1'b0}}, period_n};
      end
      default: svc = 1'b0;
    endcase
  end

  assign cur_cnt = cnt[slot];
  // period 0 always hits, so it behaves like period 1; counts never pass the period, so no wrap.
  assign hit     = (cur_cnt >= cur_per);
  assign cnt_inc = cur_cnt + CNT_ONE;

  // State register plus busy, which is registered from the next state so it tracks state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Count file and square outputs: chan_rst wins over the slot update and also suppresses its toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt[i] <= CNT_ONE;
      divq <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (chan_rst[i]) begin
          cnt[i] <= CNT_ONE;
        end else if (svc && slot == i[1:0]) begin
          cnt[i] <= hit ? CNT_ONE : cnt_inc;
          if (hit) divq[i] <= ~divq[i];
        end
      end
    end
  end

  // Sticky overrun: a dropped tick beats a clear on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

  assign div_a = divq[0];
  assign div_b = divq[1];
  assign div_c = divq[2];
  assign div_n = divq[3];

endmodule

// File: tb/tb_jt49_div_sched.sv
// Bench for jt49_div_sched: table of expected outputs per tick, hand sequences for corner cases, model-checked random run.
// Latency of each slot is checked cycle by cycle after every cen pulse.
// Inputs are driven on the falling edge and outputs sampled there too.
module tb_jt49_div_sched;
  localparam int W  = 12;
  localparam int NW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cen = 1'b0;
  logic [W-1:0]  period_a = '0;
  logic [W-1:0]  period_b = '0;
  logic [W-1:0]  period_c = '0;
  logic [NW-1:0] period_n = '0;
  logic [3:0]    chan_rst = 4'b0000;
  logic          ovr_clr = 1'b0;
  logic          div_a, div_b, div_c, div_n, busy, overrun;

  jt49_div_sched #(.W(W), .NW(NW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .period_a(period_a), .period_b(period_b), .period_c(period_c), .period_n(period_n),
    .chan_rst(chan_rst), .ovr_clr(ovr_clr),
    .div_a(div_a), .div_b(div_b), .div_c(div_c), .div_n(div_n),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ea, eb, ec, en;
  } vec_t;

  vec_t tab [12];
  int   n_vec = 0;
  int   n_bad = 0;
  int   m_cnt [4];
  logic [3:0] m_div;
  logic [3:0] m_old;
  bit   pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int per_of(input int i);
    case (i)
      0:       return int'(period_a);
      1:       return int'(period_b);
      2:       return int'(period_c);
      3:       return int'(period_n);
      default: return 0;
    endcase
  endfunction

  // Four standalone toggle dividers; rst_a models chan_rst[0] landing on the A slot.
  task automatic model_tick(input bit rst_a);
    for (int i = 0; i < 4; i++) begin
      if (i == 0 && rst_a) begin
        m_cnt[0] = 1;
      end else if (m_cnt[i] >= per_of(i)) begin
        m_cnt[i] = 1;
        m_div[i] = ~m_div[i];
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  task automatic set_per(input int a, input int b, input int c, input int n);
    period_a = W'(a);
    period_b = W'(b);
    period_c = W'(c);
    period_n = NW'(n);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_cnt[i] = 1;
    m_div = 4'b0000;
    pend  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    cen      = 1'b0;
    chan_rst = 4'b0000;
    ovr_clr  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    chk("rst_div", {div_n, div_c, div_b, div_a}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
  endtask

  // One cen pulse, gap clocks to the next; each slot checked on the cycle it lands, others held.
  task automatic tick(input int gap, input bit rst_a);
    m_old = m_div;
    model_tick(rst_a);
    cen = 1'b1;
    @(negedge clk);
    cen      = 1'b0;
    chan_rst = {3'b000, rst_a};
    if (pend) chk("div_n", div_n, m_old[3]);
    chk("busy", busy, 1);
    @(negedge clk);
    chan_rst = 4'b0000;
    chk("div_a", div_a, m_div[0]);
    chk("b_hold", div_b, m_old[1]);
    chk("c_hold", div_c, m_old[2]);
    chk("busy", busy, 1);
    @(negedge clk);
    chk("div_b", div_b, m_div[1]);
    chk("c_hold", div_c, m_old[2]);
    chk("busy", busy, 1);
    @(negedge clk);
    chk("div_c", div_c, m_div[2]);
    chk("n_hold", div_n, m_old[3]);
    chk("busy", busy, 1);
    chk("ovr_zero", overrun, 0);
    pend = 1'b1;
    repeat (gap - 4) @(negedge clk);
  endtask

  task automatic flush();
    @(negedge clk);
    if (pend) chk("div_n", div_n, m_div[3]);
    pend = 1'b0;
  endtask

  task automatic run_table();
    for (int r = 0; r < 12; r++) begin
      tick(8, 1'b0);
      chk("tab_dabcn", {div_a, div_b, div_c, div_n}, {tab[r].ea, tab[r].eb, tab[r].ec, tab[r].en});
    end
  endtask

  initial begin
    // periods a=3, b=1, c=0, n=2: expected outputs after each of 12 ticks
    tab[0]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    tab[1]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    tab[2]  = '{1'b1, 1'b1, 1'b1, 1'b1};
    tab[3]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    tab[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tab[5]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    tab[6]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    tab[7]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    tab[8]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tab[9]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    tab[10] = '{1'b1, 1'b1, 1'b1, 1'b1};
    tab[11] = '{1'b0, 1'b0, 1'b0, 1'b0};
    model_clear();

    // Basic divide ratios and slot latency
    do_reset();
    set_per(3, 1, 0, 2);
    run_table();

    // Back-to-back rounds, cen every 4 clocks
    do_reset();
    set_per(5, 1, 2, 3);
    for (int t = 1; t <= 20; t++) begin
      tick(4, 1'b0);
      if (t == 5) chk("bb_a_t5", div_a, 1);
    end
    flush();
    chk("bb_a_t20", div_a, 0);
    chk("bb_idle", busy, 0);
    chk("bb_ovr", overrun, 0);

    // Overrun: drop, hold, clear, and set-beats-clear
    do_reset();
    set_per(3, 1, 0, 2);
    cen = 1'b1;
    @(negedge clk);
    cen = 1'b0;
    @(negedge clk);
    cen = 1'b1;
    @(negedge clk);
    cen = 1'b0;
    chk("ovr_set", overrun, 1);
    repeat (6) @(negedge clk);
    chk("ovr_hold", overrun, 1);
    chk("ovr_idle", busy, 0);
    chk("ovr_one_round", {div_a, div_b, div_c, div_n}, 4'b0110);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("ovr_clr", overrun, 0);
    cen = 1'b1;
    @(negedge clk);
    cen = 1'b0;
    @(negedge clk);
    cen     = 1'b1;
    ovr_clr = 1'b1;
    @(negedge clk);
    cen     = 1'b0;
    ovr_clr = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    repeat (6) @(negedge clk);
    chk("ovr_hold2", overrun, 1);
    chk("ovr_two_rounds", {div_a, div_b, div_c, div_n}, 4'b0001);

    // Lowering the period below the current count
    do_reset();
    set_per(100, 1, 1, 1);
    for (int t = 1; t <= 50; t++) tick(4, 1'b0);
    flush();
    chk("lower_a50", div_a, 0);
    period_a = W'(10);
    tick(4, 1'b0);
    chk("lower_a51", div_a, 1);
    for (int t = 52; t <= 60; t++) tick(4, 1'b0);
    chk("lower_a60", div_a, 1);
    tick(4, 1'b0);
    chk("lower_a61", div_a, 0);
    flush();

    // chan_rst on A during its slot when count_a == period_a
    do_reset();
    set_per(3, 1, 0, 2);
    tick(8, 1'b0);
    tick(8, 1'b0);
    tick(8, 1'b1);
    chk("crst_t3", {div_a, div_b, div_c, div_n}, 4'b0111);
    tick(8, 1'b0);
    tick(8, 1'b0);
    chk("crst_t5_a", div_a, 0);
    tick(8, 1'b0);
    chk("crst_t6", {div_a, div_b, div_c, div_n}, 4'b1001);

    // Asynchronous reset while in SB, then the basic sequence again
    do_reset();
    set_per(3, 1, 0, 2);
    tick(8, 1'b0);
    cen = 1'b1;
    @(negedge clk);
    cen = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_div", {div_a, div_b, div_c, div_n}, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    chk("arst_held", {div_a, div_b, div_c, div_n, busy}, 0);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    run_table();

    // Random periods and cen spacing against the standalone model
    do_reset();
    for (int t = 0; t < 200; t++) begin
      if (t % 10 == 0) begin
        flush();
        set_per(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                int'($urandom_range(0, 20)), int'($urandom_range(0, 31)));
      end
      tick(int'($urandom_range(4, 7)), 1'b0);
    end
    flush();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
